// File: rtl/writeback_regfile_pkg.sv
// Shared architecture definitions for the writeback register file: default widths,
// register count and the queued memory-writeback record.
package writeback_regfile_pkg;

  localparam int unsigned DWIDTH_DEF = 16;
  localparam int unsigned AWIDTH_DEF = 5;
  localparam int unsigned QDEPTH_DEF = 4;
  localparam int unsigned NUM_REGS   = 32;

  // The record is sized for the widest supported configuration; narrower
  // instances zero-extend into it and truncate back out.
  localparam int unsigned DWIDTH_MAX = 64;
  localparam int unsigned AWIDTH_MAX = 8;

  typedef struct packed {
    logic                  valid;
    logic [AWIDTH_MAX-1:0] addr;
    logic [DWIDTH_MAX-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// Memory-writeback FIFO with a separate occupancy count and invalidate-by-address,
// so a younger ALU write can cancel stale queued memory results.
module wb_queue
  import writeback_regfile_pkg::*;
#(
  parameter int unsigned DWIDTH = DWIDTH_DEF,
  parameter int unsigned AWIDTH = AWIDTH_DEF,
  parameter int unsigned QDEPTH = QDEPTH_DEF,
  localparam int unsigned CntW  = $clog2(QDEPTH + 1)
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              push_i,
  input  logic [AWIDTH-1:0] push_addr_i,
  input  logic [DWIDTH-1:0] push_data_i,
  input  logic              pop_i,
  input  logic              inv_i,
  input  logic [AWIDTH-1:0] inv_addr_i,
  output logic [CntW-1:0]   count_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              head_valid_o,
  output logic [AWIDTH-1:0] head_addr_o,
  output logic [DWIDTH-1:0] head_data_o
);

  localparam int unsigned PtrW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(QDEPTH - 1);

  wb_entry_t       mem_q [QDEPTH];
  wb_entry_t       mem_d [QDEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == LastPtr) ? '0 : ptr + 1'b1;
  endfunction

  assign empty_o      = (count_q == '0);
  assign full_o       = (count_q == CntW'(QDEPTH));
  assign count_o      = count_q;
  assign head_valid_o = mem_q[rd_ptr_q].valid;
  assign head_addr_o  = AWIDTH'(mem_q[rd_ptr_q].addr);
  assign head_data_o  = DWIDTH'(mem_q[rd_ptr_q].data);

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Invalidate before pushing so an entry arriving this cycle survives.
    if (inv_i) begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (mem_q[i].addr == AWIDTH_MAX'(inv_addr_i)) begin
          mem_d[i].valid = 1'b0;
        end
      end
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (do_push) begin
      mem_d[wr_ptr_q].valid = 1'b1;
      mem_d[wr_ptr_q].addr  = AWIDTH_MAX'(push_addr_i);
      mem_d[wr_ptr_q].data  = DWIDTH_MAX'(push_data_i);
      wr_ptr_d              = ptr_inc(wr_ptr_q);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/writeback_regfile.sv
// Two-read register file with a never-stalled ALU writeback port and a queued
// memory writeback port; one register write per cycle, bypassed onto the reads.
module writeback_regfile
  import writeback_regfile_pkg::*;
#(
  parameter int unsigned DWIDTH = DWIDTH_DEF,
  parameter int unsigned AWIDTH = AWIDTH_DEF,
  parameter int unsigned QDEPTH = QDEPTH_DEF
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              aluWbEnable_i,
  input  logic [AWIDTH-1:0] aluWbAddress_i,
  input  logic [DWIDTH-1:0] aluWbData_i,
  input  logic              memWbEnable_i,
  input  logic [AWIDTH-1:0] memWbAddress_i,
  input  logic [DWIDTH-1:0] memWbData_i,
  input  logic [AWIDTH-1:0] rdAddrA_i,
  input  logic [AWIDTH-1:0] rdAddrB_i,
  output logic [DWIDTH-1:0] rdDataA_o,
  output logic [DWIDTH-1:0] rdDataB_o,
  output logic              stall_o,
  output logic              overflow_o
);

  localparam int unsigned NumRegs = 1 << AWIDTH;
  localparam int unsigned CntW    = $clog2(QDEPTH + 1);

  logic [DWIDTH-1:0] regs_q [NumRegs];
  logic [DWIDTH-1:0] regs_d [NumRegs];
  logic              overflow_q, overflow_d;

  logic              alu_we, q_pop, mem_direct, mem_to_queue, q_push, mem_drop, q_inv;
  logic [CntW-1:0]   q_count;
  logic              q_empty, q_full, head_valid;
  logic [AWIDTH-1:0] head_addr;
  logic [DWIDTH-1:0] head_data;

  logic              wr_valid, wr_en;
  logic [AWIDTH-1:0] wr_addr;
  logic [DWIDTH-1:0] wr_data;

  // Everything presented during reset is discarded.
  assign alu_we       = aluWbEnable_i && !reset_i;
  assign q_pop        = !aluWbEnable_i && !q_empty && !reset_i;
  assign mem_direct   = memWbEnable_i && !aluWbEnable_i && q_empty && !reset_i;
  assign mem_to_queue = memWbEnable_i && !mem_direct && !reset_i;
  assign q_push       = mem_to_queue && (!q_full || q_pop);
  assign mem_drop     = mem_to_queue && q_full && !q_pop;
  assign q_inv        = alu_we && (aluWbAddress_i != '0);

  wb_queue #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH),
    .QDEPTH (QDEPTH)
  ) u_wb_queue (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .push_i       (q_push),
    .push_addr_i  (memWbAddress_i),
    .push_data_i  (memWbData_i),
    .pop_i        (q_pop),
    .inv_i        (q_inv),
    .inv_addr_i   (aluWbAddress_i),
    .count_o      (q_count),
    .empty_o      (q_empty),
    .full_o       (q_full),
    .head_valid_o (head_valid),
    .head_addr_o  (head_addr),
    .head_data_o  (head_data)
  );

  // Single write port: ALU first, then the queue head, then a direct memory write.
  always_comb begin
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    if (alu_we) begin
      wr_valid = 1'b1;
      wr_addr  = aluWbAddress_i;
      wr_data  = aluWbData_i;
    end else if (q_pop) begin
      wr_valid = head_valid;
      wr_addr  = head_addr;
      wr_data  = head_data;
    end else if (mem_direct) begin
      wr_valid = 1'b1;
      wr_addr  = memWbAddress_i;
      wr_data  = memWbData_i;
    end
    wr_en = wr_valid && (wr_addr != '0);
  end

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  always_comb begin
    if (rdAddrA_i == '0) begin
      rdDataA_o = '0;
    end else if (wr_en && (rdAddrA_i == wr_addr)) begin
      rdDataA_o = wr_data;
    end else begin
      rdDataA_o = regs_q[rdAddrA_i];
    end
  end

  always_comb begin
    if (rdAddrB_i == '0) begin
      rdDataB_o = '0;
    end else if (wr_en && (rdAddrB_i == wr_addr)) begin
      rdDataB_o = wr_data;
    end else begin
      rdDataB_o = regs_q[rdAddrB_i];
    end
  end

  assign overflow_d = overflow_q || mem_drop;
  assign overflow_o = overflow_q;
  assign stall_o    = (q_count >= CntW'(QDEPTH - 1));

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      regs_q     <= '{default: '0};
      overflow_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: a queue/array reference model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_writeback_regfile;

  localparam int QD = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        alu_en, mem_en;
  logic [4:0]  alu_a, mem_a, ra, rb;
  logic [15:0] alu_d, mem_d;
  logic [15:0] rd_a, rd_b;
  logic        stall, ovf;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit          valid;
    logic [4:0]  addr;
    logic [15:0] data;
  } ent_t;

  logic [15:0] m_regs [32];
  ent_t        m_q [$];
  bit          m_ovf = 0;
  bit          chk_en = 0;

  always #5 clock = ~clock;

  writeback_regfile dut (
    .clock_i        (clock),
    .reset_i        (reset),
    .aluWbEnable_i  (alu_en),
    .aluWbAddress_i (alu_a),
    .aluWbData_i    (alu_d),
    .memWbEnable_i  (mem_en),
    .memWbAddress_i (mem_a),
    .memWbData_i    (mem_d),
    .rdAddrA_i      (ra),
    .rdAddrB_i      (rb),
    .rdDataA_o      (rd_a),
    .rdDataB_o      (rd_b),
    .stall_o        (stall),
    .overflow_o     (ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_write(input logic [4:0] a, input logic [15:0] d);
    if (a != 0) m_regs[a] = d;
  endfunction

  // The write that lands this cycle, per the port priority rules.
  function automatic logic [15:0] exp_rd(input logic [4:0] a);
    bit          cv;
    logic [4:0]  ca;
    logic [15:0] cd;
    cv = 0; ca = 0; cd = 0;
    if (!reset) begin
      if (alu_en) begin
        cv = 1; ca = alu_a; cd = alu_d;
      end else if (m_q.size() > 0) begin
        cv = m_q[0].valid; ca = m_q[0].addr; cd = m_q[0].data;
      end else if (mem_en) begin
        cv = 1; ca = mem_a; cd = mem_d;
      end
    end
    if (a == 0) return 16'h0;
    if (cv && ca == a) return cd;
    return m_regs[a];
  endfunction

  always @(posedge clock) begin : model
    ent_t e;
    bit   was_empty;
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 16'h0;
      m_q.delete();
      m_ovf  = 0;
      chk_en = 1;
    end else begin
      was_empty = (m_q.size() == 0);
      if (alu_en) begin
        m_write(alu_a, alu_d);
        if (alu_a != 0)
          foreach (m_q[i]) if (m_q[i].addr == alu_a) m_q[i].valid = 0;
      end else if (!was_empty) begin
        e = m_q.pop_front();
        if (e.valid) m_write(e.addr, e.data);
      end
      if (mem_en) begin
        if (!alu_en && was_empty) m_write(mem_a, mem_d);
        else if (m_q.size() < QD) m_q.push_back('{1'b1, mem_a, mem_d});
        else m_ovf = 1;
      end
    end
  end

  always @(negedge clock) begin : compare
    if (chk_en) begin
      check("model_rdA", {16'h0, rd_a}, {16'h0, exp_rd(ra)});
      check("model_rdB", {16'h0, rd_b}, {16'h0, exp_rd(rb)});
      check("model_stall", {31'h0, stall}, {31'h0, m_q.size() >= QD - 1});
      check("model_overflow", {31'h0, ovf}, {31'h0, m_ovf});
    end
  end

  // Apply one cycle of inputs just after the edge; returns at the following negedge.
  task automatic drive(input bit r, input bit ae, input logic [4:0] aa, input logic [15:0] ad,
                       input bit me, input logic [4:0] ma, input logic [15:0] md,
                       input logic [4:0] a, input logic [4:0] b);
    @(posedge clock);
    #1;
    reset = r; alu_en = ae; alu_a = aa; alu_d = ad;
    mem_en = me; mem_a = ma; mem_d = md; ra = a; rb = b;
    @(negedge clock);
  endtask

  task automatic idle(input logic [4:0] a, input logic [4:0] b);
    drive(0, 0, 0, 0, 0, 0, 0, a, b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1; alu_en = 0; alu_a = 0; alu_d = 0;
    mem_en = 0; mem_a = 0; mem_d = 0; ra = 0; rb = 0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 3, 5);
    idle(3, 5);
    check("reset_rdA", {16'h0, rd_a}, 32'h0);
    check("reset_stall", {31'h0, stall}, 32'h0);
    check("reset_overflow", {31'h0, ovf}, 32'h0);

    // ALU write with same-cycle bypass
    drive(0, 1, 3, 16'h1234, 0, 0, 0, 3, 0);
    check("alu_bypass_R3", {16'h0, rd_a}, 32'h1234);
    idle(3, 0);
    check("alu_held_R3", {16'h0, rd_a}, 32'h1234);

    // ALU and memory together: memory queued, committed on the next idle cycle
    drive(0, 1, 5, 16'h0001, 1, 6, 16'h0002, 5, 6);
    check("dual_R5_bypass", {16'h0, rd_a}, 32'h0001);
    check("dual_R6_not_yet", {16'h0, rd_b}, 32'h0);
    idle(5, 6);
    check("dual_R6_drain_bypass", {16'h0, rd_b}, 32'h0002);
    idle(6, 5);
    check("dual_R6_held", {16'h0, rd_a}, 32'h0002);

    // Queued R7 is invalidated by a younger ALU write
    drive(0, 1, 1, 16'h1111, 1, 7, 16'hAAAA, 7, 1);
    drive(0, 1, 7, 16'hBBBB, 0, 0, 0, 7, 1);
    idle(7, 0);
    check("inv_drain_R7", {16'h0, rd_a}, 32'hBBBB);
    idle(7, 1);
    check("inv_final_R7", {16'h0, rd_a}, 32'hBBBB);

    // Pop and push in the same cycle keep the count
    drive(0, 1, 1, 16'h2222, 1, 20, 16'h0020, 20, 21);
    drive(0, 0, 0, 0, 1, 21, 16'h0021, 20, 21);
    check("popush_R20_bypass", {16'h0, rd_a}, 32'h0020);
    idle(21, 20);
    check("popush_R21_bypass", {16'h0, rd_a}, 32'h0021);
    idle(20, 21);
    check("popush_R20", {16'h0, rd_a}, 32'h0020);
    check("popush_R21", {16'h0, rd_b}, 32'h0021);

    // Fill the queue with the ALU busy; the fifth memory write overflows
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 2, 16'(i), 1, 5'(10 + i), 16'(16'h0100 + i), 5'(10 + i), 2);
      if (i == 2) check("fill_stall_low_at_2", {31'h0, stall}, 32'h0);
      if (i == 3) check("fill_stall_high_at_3", {31'h0, stall}, 32'h1);
    end
    idle(10, 14);
    check("fill_overflow_set", {31'h0, ovf}, 32'h1);
    for (int i = 0; i < 4; i++) idle(5'(10 + i), 14);
    idle(13, 14);
    check("fill_R13", {16'h0, rd_a}, 32'h0103);
    check("fill_R14_dropped", {16'h0, rd_b}, 32'h0);
    check("fill_overflow_sticky", {31'h0, ovf}, 32'h1);
    check("fill_stall_drained", {31'h0, stall}, 32'h0);

    // Register 0 writes are discarded from either port
    drive(0, 1, 0, 16'hFFFF, 0, 0, 0, 0, 0);
    check("r0_alu_bypass", {16'h0, rd_a}, 32'h0);
    drive(0, 0, 0, 0, 1, 0, 16'hFFFF, 0, 0);
    check("r0_mem_bypass", {16'h0, rd_b}, 32'h0);
    idle(0, 3);
    check("r0_read", {16'h0, rd_a}, 32'h0);

    // Reset with two entries queued drops them and clears overflow
    drive(0, 1, 1, 16'h3333, 1, 22, 16'h0022, 22, 23);
    drive(0, 1, 1, 16'h4444, 1, 23, 16'h0023, 22, 23);
    drive(1, 1, 9, 16'h9999, 1, 24, 16'h0024, 9, 24);
    idle(3, 9);
    check("rst_mid_R3", {16'h0, rd_a}, 32'h0);
    check("rst_mid_R9", {16'h0, rd_b}, 32'h0);
    check("rst_mid_overflow", {31'h0, ovf}, 32'h0);
    check("rst_mid_stall", {31'h0, stall}, 32'h0);
    idle(22, 23);
    check("rst_mid_R22", {16'h0, rd_a}, 32'h0);
    check("rst_mid_R23", {16'h0, rd_b}, 32'h0);

    // Post-reset traffic and a full read sweep against the model
    drive(0, 1, 4, 16'h0404, 1, 8, 16'h0808, 4, 8);
    drive(0, 0, 0, 0, 1, 9, 16'h0909, 8, 9);
    idle(9, 8);
    for (int i = 0; i < 32; i++) idle(5'(i), 5'(31 - i));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
